// File: rtl/complex_acc_pkg.sv
// Shared widths, FSM encoding and acc_len clamp for the complex result accumulator.
package complex_acc_pkg;

    localparam int unsigned DATA_WIDTH = 8;
    localparam int unsigned RES_WIDTH  = 2 * DATA_WIDTH + 2;
    localparam int unsigned MAX_LEN    = 16;
    localparam int unsigned LEN_W      = $clog2(MAX_LEN + 1);
    localparam int unsigned ACC_WIDTH  = RES_WIDTH + $clog2(MAX_LEN);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StAcc  = 2'd1;
    localparam logic [1:0] StHold = 2'd2;

    // A zero length still yields a one-product sum; overlong requests saturate.
    function automatic int unsigned clamp_len(input int unsigned len,
                                              input int unsigned max_len);
        if (len == 32'd0) begin
            return 32'd1;
        end else if (len > max_len) begin
            return max_len;
        end else begin
            return len;
        end
    endfunction

endpackage

// File: rtl/complex_result_accumulator_if.sv
// Product input channel, sum output channel and status for the accumulator.
interface complex_result_accumulator_if
    import complex_acc_pkg::*;
#(
    parameter int unsigned RES_W = RES_WIDTH,
    parameter int unsigned ACC_W = ACC_WIDTH,
    parameter int unsigned LEN_WIDTH = LEN_W
);

    logic [LEN_WIDTH-1:0] acc_len;
    logic                 res_val;
    logic                 res_ready;
    logic [2*RES_W-1:0]   res_data;
    logic                 sum_val;
    logic                 sum_ready;
    logic [2*ACC_W-1:0]   sum_data;
    logic                 busy;

    modport master (
        output acc_len, res_val, res_data, sum_ready,
        input  res_ready, sum_val, sum_data, busy
    );

    modport slave (
        input  acc_len, res_val, res_data, sum_ready,
        output res_ready, sum_val, sum_data, busy
    );

endinterface

// File: rtl/cplx_acc_adder.sv
// Sign-extends a {re, im} product and adds it into a {re, im} accumulator.
module cplx_acc_adder
    import complex_acc_pkg::*;
#(
    parameter int unsigned RES_W = RES_WIDTH,
    parameter int unsigned ACC_W = ACC_WIDTH
) (
    input  logic [2*ACC_W-1:0] acc_i,
    input  logic [2*RES_W-1:0] prod_i,
    output logic [2*ACC_W-1:0] sum_o
);

    logic [RES_W-1:0] p_re;
    logic [RES_W-1:0] p_im;
    logic [ACC_W-1:0] x_re;
    logic [ACC_W-1:0] x_im;
    logic [ACC_W-1:0] a_re;
    logic [ACC_W-1:0] a_im;
    logic [ACC_W-1:0] s_re;
    logic [ACC_W-1:0] s_im;

    always_comb begin
        p_re  = prod_i[2*RES_W-1:RES_W];
        p_im  = prod_i[RES_W-1:0];
        a_re  = acc_i[2*ACC_W-1:ACC_W];
        a_im  = acc_i[ACC_W-1:0];
        x_re  = {{(ACC_W - RES_W){p_re[RES_W-1]}}, p_re};
        x_im  = {{(ACC_W - RES_W){p_im[RES_W-1]}}, p_im};
        // Headroom of ACC_W over RES_W makes the carry out unreachable.
        s_re  = a_re + x_re;
        s_im  = a_im + x_im;
        sum_o = {s_re, s_im};
    end

endmodule

// File: rtl/complex_result_accumulator.sv
// Sums a programmable number of complex products and presents the sum on valid/ready.
module complex_result_accumulator #(
    parameter int unsigned DATA_WIDTH = complex_acc_pkg::DATA_WIDTH,
    parameter int unsigned MAX_LEN    = complex_acc_pkg::MAX_LEN
) (
    input logic                         clk,
    input logic                         sw_rst,
    complex_result_accumulator_if.slave bus
);

    localparam int unsigned RES_WIDTH = 2 * DATA_WIDTH + 2;
    localparam int unsigned LEN_W     = $clog2(MAX_LEN + 1);
    localparam int unsigned ACC_WIDTH = RES_WIDTH + $clog2(MAX_LEN);

    import complex_acc_pkg::*;

    logic [1:0]             state_q;
    logic [1:0]             state_d;
    logic [ACC_WIDTH-1:0]   acc_re_q;
    logic [ACC_WIDTH-1:0]   acc_re_d;
    logic [ACC_WIDTH-1:0]   acc_im_q;
    logic [ACC_WIDTH-1:0]   acc_im_d;
    logic [LEN_W-1:0]       len_q;
    logic [LEN_W-1:0]       len_d;
    logic [LEN_W-1:0]       cnt_q;
    logic [LEN_W-1:0]       cnt_d;

    logic                   res_xfer;
    logic [LEN_W-1:0]       len_clamped;
    logic [LEN_W-1:0]       cnt_inc;
    logic [2*ACC_WIDTH-1:0] adder_acc;
    logic [2*ACC_WIDTH-1:0] adder_sum;

    always_comb begin
        bus.res_ready = ~sw_rst & (state_q != StHold);
        bus.sum_val   = ~sw_rst & (state_q == StHold);
        bus.busy      = ~sw_rst & (state_q == StAcc);
        bus.sum_data  = sw_rst ? '0 : {acc_re_q, acc_im_q};
    end

    always_comb begin
        res_xfer    = bus.res_val & bus.res_ready;
        len_clamped = LEN_W'(clamp_len(32'(bus.acc_len), MAX_LEN));
        cnt_inc     = cnt_q + 1'b1;
        // The first product of a frame loads rather than adds, so feed a zero accumulator.
        adder_acc   = (state_q == StIdle) ? '0 : {acc_re_q, acc_im_q};
    end

    cplx_acc_adder #(
        .RES_W (RES_WIDTH),
        .ACC_W (ACC_WIDTH)
    ) u_adder (
        .acc_i  (adder_acc),
        .prod_i (bus.res_data),
        .sum_o  (adder_sum)
    );

    always_comb begin
        state_d  = state_q;
        acc_re_d = acc_re_q;
        acc_im_d = acc_im_q;
        len_d    = len_q;
        cnt_d    = cnt_q;

        case (state_q)
            StIdle: begin
                if (res_xfer) begin
                    {acc_re_d, acc_im_d} = adder_sum;
                    len_d                = len_clamped;
                    cnt_d                = LEN_W'(1);
                    state_d              = (len_clamped == LEN_W'(1)) ? StHold : StAcc;
                end
            end
            StAcc: begin
                if (res_xfer) begin
                    {acc_re_d, acc_im_d} = adder_sum;
                    cnt_d                = cnt_inc;
                    if (cnt_inc == len_q) begin
                        state_d = StHold;
                    end
                end
            end
            StHold: begin
                if (bus.sum_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (sw_rst) begin
            state_q  <= StIdle;
            acc_re_q <= '0;
            acc_im_q <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            acc_re_q <= acc_re_d;
            acc_im_q <= acc_im_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_complex_result_accumulator.sv
// Randomized bench for complex_result_accumulator against a frame-level sum model.
module tb_complex_result_accumulator;

    localparam int RW   = 18;
    localparam int AW   = 22;
    localparam int LW   = 5;
    localparam int MAXL = 16;

    logic        clk = 1'b0;
    logic        sw_rst;
    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [2*RW-1:0] prod_q[$];

    complex_result_accumulator_if bus ();

    complex_result_accumulator dut (
        .clk    (clk),
        .sw_rst (sw_rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2*RW-1:0] mk_prod(input int re, input int im);
        logic [31:0] r;
        logic [31:0] i;
        r = re;
        i = im;
        return {r[RW-1:0], i[RW-1:0]};
    endfunction

    function automatic logic [2*RW-1:0] rand_prod();
        return mk_prod(int'($urandom_range(0, 260100)) - 130050,
                       int'($urandom_range(0, 260100)) - 130050);
    endfunction

    function automatic int ref_len(input int l);
        if (l == 0) return 1;
        if (l > MAXL) return MAXL;
        return l;
    endfunction

    task automatic push_product(input logic [2*RW-1:0] p);
        bit done;
        bit ready_now;
        done = 1'b0;
        bus.res_val  = 1'b1;
        bus.res_data = p;
        for (int c = 0; c < 64; c++) begin
            ready_now = bus.res_ready;
            step();
            if (ready_now) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) check_eq("res_timeout", 64'(0), 64'(1));
        bus.res_val = 1'b0;
    endtask

    // One whole frame: push the modelled number of products, then drain the sum.
    task automatic run_frame(input int len_cfg, input int len_alt, input int hold,
                             input bit keep_val);
        int eff;
        longint re_s;
        longint im_s;
        logic [2*RW-1:0] p;
        logic signed [RW-1:0] pr;
        logic signed [RW-1:0] pi;
        logic [63:0] re_l;
        logic [63:0] im_l;
        logic [2*AW-1:0] want_sum;
        eff  = ref_len(len_cfg);
        re_s = 0;
        im_s = 0;
        bus.acc_len = LW'(len_cfg);
        for (int k = 1; k <= eff; k++) begin
            if (!bus.res_val && $urandom_range(0, 2) == 0) step();
            p = prod_q.pop_front();
            push_product(p);
            if (k == 1) bus.acc_len = LW'(len_alt);
            pr = p[2*RW-1:RW];
            pi = p[RW-1:0];
            re_s += longint'(pr);
            im_s += longint'(pi);
            check_eq("busy", 64'(bus.busy), 64'(k < eff));
            if (k < eff) check_eq("early_sum_val", 64'(bus.sum_val), 64'(0));
        end
        re_l = re_s;
        im_l = im_s;
        want_sum = {re_l[AW-1:0], im_l[AW-1:0]};
        check_eq("sum_val", 64'(bus.sum_val), 64'(1));
        check_eq("sum_data", 64'(bus.sum_data), 64'(want_sum));
        bus.sum_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            if (keep_val && prod_q.size() > 0) begin
                bus.res_val  = 1'b1;
                bus.res_data = prod_q[0];
            end
            step();
            check_eq("hold_res_ready", 64'(bus.res_ready), 64'(0));
            check_eq("hold_sum_val", 64'(bus.sum_val), 64'(1));
            check_eq("hold_sum_data", 64'(bus.sum_data), 64'(want_sum));
        end
        bus.sum_ready = 1'b1;
        step();
        bus.sum_ready = 1'b0;
        check_eq("drained_sum_val", 64'(bus.sum_val), 64'(0));
        check_eq("idle_res_ready", 64'(bus.res_ready), 64'(1));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        int alt;
        int hold;
        bit keep;

        sw_rst        = 1'b1;
        bus.res_val   = 1'b0;
        bus.res_data  = '0;
        bus.acc_len   = '0;
        bus.sum_ready = 1'b0;
        step();
        step();
        check_eq("rst_res_ready", 64'(bus.res_ready), 64'(0));
        check_eq("rst_sum_val", 64'(bus.sum_val), 64'(0));
        check_eq("rst_busy", 64'(bus.busy), 64'(0));
        check_eq("rst_sum_data", 64'(bus.sum_data), 64'(0));
        sw_rst = 1'b0;
        #1;
        check_eq("post_rst_res_ready", 64'(bus.res_ready), 64'(1));

        // Single product (2+3i)(4+2i).
        prod_q.push_back(mk_prod(2, 16));
        run_frame(1, 1, 0, 1'b0);

        // Four worst-case im products.
        for (int i = 0; i < 4; i++) prod_q.push_back(mk_prod(0, 130050));
        run_frame(4, 4, 1, 1'b0);

        // Sixteen negative re products.
        for (int i = 0; i < 16; i++) prod_q.push_back(mk_prod(-65025, 0));
        run_frame(16, 16, 0, 1'b0);

        // Backpressure with the next product waiting in HOLD.
        for (int i = 0; i < 3; i++) prod_q.push_back(rand_prod());
        prod_q.push_back(mk_prod(-3, 9));
        run_frame(3, 3, 5, 1'b1);
        run_frame(1, 1, 0, 1'b0);

        // Reset in the middle of a frame.
        bus.acc_len = LW'(4);
        push_product(mk_prod(5, 6));
        push_product(mk_prod(5, 6));
        check_eq("mid_busy", 64'(bus.busy), 64'(1));
        sw_rst = 1'b1;
        #1;
        check_eq("mid_rst_res_ready", 64'(bus.res_ready), 64'(0));
        check_eq("mid_rst_busy", 64'(bus.busy), 64'(0));
        step();
        sw_rst = 1'b0;
        #1;
        check_eq("mid_post_sum_val", 64'(bus.sum_val), 64'(0));
        check_eq("mid_post_busy", 64'(bus.busy), 64'(0));
        check_eq("mid_post_sum_data", 64'(bus.sum_data), 64'(0));
        step();
        step();
        check_eq("mid_no_sum_val", 64'(bus.sum_val), 64'(0));
        for (int i = 0; i < 2; i++) prod_q.push_back(mk_prod(1, 1));
        run_frame(2, 2, 0, 1'b0);

        // Reset while a sum is held.
        bus.acc_len = LW'(1);
        push_product(mk_prod(7, -7));
        check_eq("hold_rst_pre_val", 64'(bus.sum_val), 64'(1));
        sw_rst = 1'b1;
        #1;
        check_eq("hold_rst_val", 64'(bus.sum_val), 64'(0));
        step();
        sw_rst = 1'b0;
        #1;
        check_eq("hold_rst_post_val", 64'(bus.sum_val), 64'(0));
        check_eq("hold_rst_post_data", 64'(bus.sum_data), 64'(0));

        // Length edge cases.
        prod_q.push_back(rand_prod());
        run_frame(0, 0, 0, 1'b0);
        for (int i = 0; i < 16; i++) prod_q.push_back(rand_prod());
        run_frame(31, 31, 1, 1'b0);
        for (int i = 0; i < 3; i++) prod_q.push_back(rand_prod());
        run_frame(3, 1, 0, 1'b0);

        // Random frames.
        for (int f = 0; f < 25; f++) begin
            len  = int'($urandom_range(0, 31));
            alt  = int'($urandom_range(0, 31));
            hold = int'($urandom_range(0, 3));
            keep = (f < 24) && ($urandom_range(0, 1) == 1);
            while (prod_q.size() < 18) prod_q.push_back(rand_prod());
            run_frame(len, alt, hold, keep);
        end
        bus.res_val = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/complex_result_accumulator.md
Name: complex_result_accumulator

Overview:
- Downstream consumer of the complex number multiplier. Accepts products over the multiplier's result handshake (res_val/res_ready) and sums a programmable number of consecutive products into one complex sum (a complex dot product).
- Presents each finished sum on a valid/ready output toward the next consumer.
- Single clock domain.

Parameters:
- DATA_WIDTH, 8, operand width of the upstream multiplier.
- RES_WIDTH, 2*DATA_WIDTH+2, signed width of each product component (re or im).
- MAX_LEN, 16, maximum number of products per sum.
- LEN_W, $clog2(MAX_LEN+1), width of acc_len.
- ACC_WIDTH, RES_WIDTH+$clog2(MAX_LEN), signed width of each sum component.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- sw_rst  input  1  synchronous reset, active-high; the only reset.
- acc_len  input  LEN_W  products per sum; sampled on the first accepted product of a frame.
- res_val  input  1  upstream product valid.
- res_ready  output  1  block can accept a product.
- res_data  input  2*RES_WIDTH  product {re, im}, two's complement, re in the MSBs.
- sum_val  output  1  sum valid.
- sum_ready  input  1  downstream accepts the sum.
- sum_data  output  2*ACC_WIDTH  sum {re, im}, two's complement, re in the MSBs.
- busy  output  1  high while a frame is partially accumulated.

Behaviour:
- Reset: sw_rst is sampled on a clock edge and is the only reset. While sw_rst is high:
  - state goes to IDLE; accumulators, counter and latched length go to 0.
  - sum_val=0, sum_data=0, busy=0, res_ready=0.
- Transfer rule: a transfer occurs on a clock edge where val&ready are both high. Once sum_val is asserted it holds, with sum_data stable, until the transfer.
- res_ready = ~sw_rst & (state != HOLD).
- FSM state IDLE (busy=0):
  - On a product transfer: acc_re/acc_im <= sign-extended res_data components.
  - len_q <= clamp(acc_len), where 0 maps to 1 and values above MAX_LEN map to MAX_LEN.
  - cnt <= 1.
  - Next state is HOLD if the clamped length is 1, else ACC.
- FSM state ACC (busy=1):
  - On a product transfer: acc += sign-extended product, cnt++.
  - If this was product number len_q, next state is HOLD.
  - With no transfer, the state is held indefinitely.
- FSM state HOLD (busy=0):
  - sum_val=1 and sum_data={acc_re, acc_im}; no products are accepted.
  - On sum_ready: next state is IDLE and accumulators clear on the following accepted product (the IDLE load overwrites them).
- Latency: sum_val rises one cycle after the edge that accepted the last product. The minimum gap between frames is 1 cycle (the HOLD cycle).
- Arithmetic:
  - Sign-extend each RES_WIDTH component to ACC_WIDTH; the re and im adders are independent.
  - ACC_WIDTH guarantees no overflow for MAX_LEN worst-case products, so no saturation logic.
- Boundary conditions:
  - acc_len changing mid-frame is ignored; the latched len_q governs.
  - sw_rst mid-frame discards the partial sum and never produces sum_val.
  - sw_rst in HOLD drops sum_val without a transfer.
  - res_val held high in HOLD is back-pressured; no product is lost or duplicated.

Decomposition:
- Package complex_acc_pkg: RES_WIDTH/ACC_WIDTH/LEN_W derivations, FSM state encoding (IDLE, ACC, HOLD), and a clamp function for acc_len.
- One sub-module, cplx_acc_adder: combinational sign-extend plus add of a {re, im} product into a {re, im} accumulator. It is instantiated once; the registers stay in the top.

Test Plan:
1. acc_len=1, one product {re=2, im=16} (from (2+3i)(4+2i)) -> sum_val one cycle later, sum_data re=2 im=16; busy stays 0.
2. acc_len=4, four corner products {re=0, im=130050} with DATA_WIDTH=8 and all operands 255 -> sum re=0 im=520200, with no overflow in 22 bits.
3. acc_len=16, sixteen products {re=-65025, im=0} -> sum re=-1040400 im=0; sign correct; busy high from the 1st through the 15th transfer.
4. Backpressure: sum_ready low for 5 cycles after sum_val, res_val high with the next product -> res_ready=0 and sum_data stable throughout. After sum_ready=1, the next product is accepted in IDLE and forms a new frame.
5. Mid-frame reset: acc_len=4, 2 products accepted, then sw_rst for 1 cycle -> no sum_val and all outputs 0. Then acc_len=2 with {1, 1} twice -> sum {2, 2}.
6. Length edge cases:
   - acc_len=0 behaves as 1.
   - acc_len=31 clamps to 16.
   - acc_len changed from 3 to 1 after the first product still yields a 3-product sum.
